// File: rtl/gpio_pattern_seq_pkg.sv
// Shared types and default sizing for the GPIO pattern sequencer.
package gpio_pattern_seq_pkg;

  localparam int unsigned DefDepth  = 8;
  localparam int unsigned DefTimerW = 16;
  localparam int unsigned MaxTimerW = 32;
  localparam int unsigned PassCntW  = 16;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    HOLD
  } state_e;

  // hold is sized for the widest supported TimerW; narrower builds zero-extend.
  typedef struct packed {
    logic [31:0]          mask;
    logic [31:0]          data;
    logic [MaxTimerW-1:0] hold;
  } entry_t;

endpackage

// File: rtl/gpio_pattern_seq_tbl.sv
// Pattern table: flop array with one write port and one combinational read port.
module gpio_pattern_seq_tbl
  import gpio_pattern_seq_pkg::*;
#(
  parameter int unsigned Depth = DefDepth
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     we,
  input  logic [$clog2(Depth)-1:0] waddr,
  input  entry_t                   wentry,
  input  logic [$clog2(Depth)-1:0] raddr,
  output entry_t                   rentry
);

  entry_t mem [Depth];

  // NOTE: the array is flop-based, so it can be reset; a RAM macro could not be.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < Depth; i++) mem[i] <= '0;
    end else if (we) begin
      mem[waddr] <= wentry;
    end
  end

  assign rentry = mem[raddr];

endmodule

// File: rtl/gpio_pattern_seq.sv
// Plays a table of masked GPIO writes with per-entry hold times.
// Optional pass counter: define GPIO_PATTERN_SEQ_PASS_CNT_EN to build it.
module gpio_pattern_seq
  import gpio_pattern_seq_pkg::*;
#(
  parameter int unsigned Depth  = DefDepth,
  parameter int unsigned TimerW = DefTimerW
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     cfg_we_i,
  input  logic [$clog2(Depth)-1:0] cfg_addr_i,
  input  logic [31:0]              cfg_mask_i,
  input  logic [31:0]              cfg_data_i,
  input  logic [TimerW-1:0]        cfg_hold_i,
  input  logic                     start_i,
  input  logic                     stop_i,
  input  logic                     loop_i,
  input  logic [$clog2(Depth):0]   len_i,
  output logic                     wr_valid_o,
  output logic [31:0]              wr_mask_o,
  output logic [31:0]              wr_data_o,
  input  logic                     wr_ready_i,
  output logic                     busy_o,
  output logic                     done_o,
  output logic [$clog2(Depth)-1:0] idx_o,
  output logic [PassCntW-1:0]      pass_cnt_o
);

  localparam int unsigned AW = $clog2(Depth);
  localparam logic [AW:0] DepthLen = (AW+1)'(Depth);

  state_e            state;
  logic [AW-1:0]     idx;
  logic [AW-1:0]     len_last;
  logic              loop_q;
  logic [TimerW-1:0] timer;
  logic [AW:0]       len_clamped;
  logic [AW:0]       len_m1;
  logic              tbl_we;
  logic              last;
  logic              advance;
  entry_t            wr_entry;
  entry_t            rd_entry;
  logic              unused_hold;

  assign tbl_we  = cfg_we_i && (state == IDLE);
  assign wr_entry = '{mask: cfg_mask_i, data: cfg_data_i, hold: MaxTimerW'(cfg_hold_i)};

  gpio_pattern_seq_tbl #(
    .Depth(Depth)
  ) u_tbl (
    .clk_i (clk_i),
    .rst_ni(rst_ni),
    .we    (tbl_we),
    .waddr (cfg_addr_i),
    .wentry(wr_entry),
    .raddr (idx),
    .rentry(rd_entry)
  );

  assign unused_hold = ^rd_entry.hold;

  assign len_clamped = (len_i > DepthLen) ? DepthLen : len_i;
  assign len_m1      = len_clamped - (AW+1)'(1);
  assign last        = (idx == len_last);
  assign advance     = (state == HOLD) && (timer == '0);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state      <= IDLE;
      idx        <= '0;
      len_last   <= '0;
      loop_q     <= 1'b0;
      timer      <= '0;
      wr_valid_o <= 1'b0;
      done_o     <= 1'b0;
    end else begin
      done_o <= 1'b0;
      if (stop_i) begin
        state      <= IDLE;
        wr_valid_o <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (start_i) begin
              if (len_clamped == '0) begin
                done_o <= 1'b1;
              end else begin
                len_last   <= len_m1[AW-1:0];
                loop_q     <= loop_i;
                idx        <= '0;
                wr_valid_o <= 1'b1;
                state      <= ISSUE;
              end
            end
          end
          ISSUE: begin
            if (wr_ready_i) begin
              timer      <= rd_entry.hold[TimerW-1:0];
              wr_valid_o <= 1'b0;
              state      <= HOLD;
            end
          end
          HOLD: begin
            if (timer != '0) begin
              timer <= timer - TimerW'(1);
            end else if (!last) begin
              idx        <= idx + AW'(1);
              wr_valid_o <= 1'b1;
              state      <= ISSUE;
            end else if (loop_q) begin
              idx        <= '0;
              wr_valid_o <= 1'b1;
              state      <= ISSUE;
            end else begin
              done_o <= 1'b1;
              state  <= IDLE;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  // The table cannot change while busy, so gating the live read is stable.
  assign wr_mask_o = wr_valid_o ? rd_entry.mask : '0;
  assign wr_data_o = wr_valid_o ? rd_entry.data : '0;
  assign busy_o    = (state != IDLE);
  assign idx_o     = idx;

`ifdef GPIO_PATTERN_SEQ_PASS_CNT_EN
  logic [PassCntW-1:0] pass_cnt;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pass_cnt <= '0;
    end else if (!stop_i) begin
      if (state == IDLE && start_i) begin
        pass_cnt <= '0;
      end else if (advance && last && (pass_cnt != '1)) begin
        pass_cnt <= pass_cnt + PassCntW'(1);
      end
    end
  end

  assign pass_cnt_o = pass_cnt;
`else
  logic unused_advance;
  assign unused_advance = advance;
  assign pass_cnt_o     = '0;
`endif

endmodule

// File: tb/tb_gpio_pattern_seq.sv
// Randomized bench for gpio_pattern_seq with a timing-rule reference model.
module tb_gpio_pattern_seq;

  localparam int Depth  = 8;
  localparam int AW     = 3;
  localparam int TimerW = 16;

  logic              clk_i = 1'b0;
  logic              rst_ni = 1'b0;
  logic              cfg_we_i = 1'b0;
  logic [AW-1:0]     cfg_addr_i = '0;
  logic [31:0]       cfg_mask_i = '0;
  logic [31:0]       cfg_data_i = '0;
  logic [TimerW-1:0] cfg_hold_i = '0;
  logic              start_i = 1'b0;
  logic              stop_i = 1'b0;
  logic              loop_i = 1'b0;
  logic [AW:0]       len_i = '0;
  logic              wr_valid_o;
  logic [31:0]       wr_mask_o;
  logic [31:0]       wr_data_o;
  logic              wr_ready_i = 1'b0;
  logic              busy_o;
  logic              done_o;
  logic [AW-1:0]     idx_o;
  logic [15:0]       pass_cnt_o;

  int checks = 0;
  int errors = 0;

  logic [31:0] m_mask [Depth];
  logic [31:0] m_data [Depth];
  int          m_hold [Depth];

  gpio_pattern_seq dut (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .cfg_we_i  (cfg_we_i),
    .cfg_addr_i(cfg_addr_i),
    .cfg_mask_i(cfg_mask_i),
    .cfg_data_i(cfg_data_i),
    .cfg_hold_i(cfg_hold_i),
    .start_i   (start_i),
    .stop_i    (stop_i),
    .loop_i    (loop_i),
    .len_i     (len_i),
    .wr_valid_o(wr_valid_o),
    .wr_mask_o (wr_mask_o),
    .wr_data_o (wr_data_o),
    .wr_ready_i(wr_ready_i),
    .busy_o    (busy_o),
    .done_o    (done_o),
    .idx_o     (idx_o),
    .pass_cnt_o(pass_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  function automatic logic [15:0] exp_pc(input int p);
`ifdef GPIO_PATTERN_SEQ_PASS_CNT_EN
    return 16'(p);
`else
    return (p < 0) ? 16'hFFFF : 16'h0000;
`endif
  endfunction

  task automatic clear_model();
    for (int i = 0; i < Depth; i++) begin
      m_mask[i] = '0;
      m_data[i] = '0;
      m_hold[i] = 0;
    end
  endtask

  task automatic write_entry(input int a, input logic [31:0] m, input logic [31:0] d, input int h);
    @(negedge clk_i);
    cfg_we_i   = 1'b1;
    cfg_addr_i = AW'(a);
    cfg_mask_i = m;
    cfg_data_i = d;
    cfg_hold_i = TimerW'(h);
    @(negedge clk_i);
    cfg_we_i = 1'b0;
    m_mask[a] = m;
    m_data[a] = d;
    m_hold[a] = h;
  endtask

  // Model: a write rises 1 cycle after start, stays until accepted, and the
  // next one rises hold+2 cycles after each accept; a pass (and done for a
  // non-looping run) lands on that same cycle after the last entry.
  task automatic run_model(input int len_in, input bit loop, input bit rnd_ready, input int stop_pass);
    int eff, rise, e, passes, pass_at, done_at, end_at, h;
    bit waiting, exp_valid, r;
    logic [2:0]  exp_vdb;
    logic [66:0] exp_out;
    eff = (len_in > Depth) ? Depth : len_in;
    rise = 1; e = 0; passes = 0; pass_at = -1; done_at = -1; end_at = -1; waiting = 1'b1;
    start_i = 1'b1; len_i = (AW+1)'(len_in); loop_i = loop; wr_ready_i = 1'b1;
    for (int c = 1; c <= 2000; c++) begin
      @(negedge clk_i);
      start_i = 1'b0;
      stop_i  = 1'b0;
      if (c == pass_at) passes++;
      exp_valid = waiting && (c >= rise) && (end_at < 0);
      exp_vdb = {exp_valid, c == done_at, (end_at < 0) || (c < end_at)};
      checks++;
      if ({wr_valid_o, done_o, busy_o} !== exp_vdb) begin
        errors++;
        $display("FAIL run_vdb len=%0d c=%0d got %b exp %b", len_in, c, {wr_valid_o, done_o, busy_o}, exp_vdb);
      end
      checks++;
      if (pass_cnt_o !== exp_pc(passes)) begin
        errors++;
        $display("FAIL run_pass_cnt c=%0d got %0d exp %0d", c, pass_cnt_o, exp_pc(passes));
      end
      if (exp_valid) begin
        exp_out = {m_mask[e], m_data[e], AW'(e)};
        checks++;
        if ({wr_mask_o, wr_data_o, idx_o} !== exp_out) begin
          errors++;
          $display("FAIL run_write c=%0d got %h/%h/%0d exp %h/%h/%0d", c, wr_mask_o, wr_data_o, idx_o,
                   m_mask[e], m_data[e], e);
        end
      end
      if (end_at >= 0 && c >= end_at) return;
      r = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      wr_ready_i = r;
      if (exp_valid && stop_pass > 0 && passes == stop_pass) begin
        stop_i = 1'b1;
        end_at = c + 1;
      end else if (exp_valid && r) begin
        h = m_hold[e];
        rise = c + h + 2;
        e++;
        if (e == eff) begin
          e = 0;
          pass_at = rise;
          if (!loop) begin
            waiting = 1'b0;
            done_at = rise;
            end_at  = rise;
          end
        end
      end
    end
    errors++;
    $display("FAIL run_timeout len=%0d got no completion exp completion within 2000 cycles", len_in);
  endtask

  task automatic test_reset();
    @(negedge clk_i);
    @(negedge clk_i);
    checks++;
    if ({wr_valid_o, wr_mask_o, wr_data_o, busy_o, done_o, idx_o, pass_cnt_o} !== '0) begin
      errors++;
      $display("FAIL reset_outputs got v=%b m=%h d=%h b=%b dn=%b i=%0d p=%0d exp all zero",
               wr_valid_o, wr_mask_o, wr_data_o, busy_o, done_o, idx_o, pass_cnt_o);
    end
    rst_ni = 1'b1;
    clear_model();
    @(negedge clk_i);
  endtask

  task automatic test_basic();
    logic [2:0] exp;
    write_entry(0, 32'hFFFF0000, 32'hA5A50000, 3);
    write_entry(1, 32'h0000FFFF, 32'h00005A5A, 0);
    wr_ready_i = 1'b1; start_i = 1'b1; len_i = 4'd2; loop_i = 1'b0;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk_i);
      start_i = 1'b0;
      exp = {(c == 1) || (c == 6), c == 8, c < 8};
      checks++;
      if ({wr_valid_o, done_o, busy_o} !== exp) begin
        errors++;
        $display("FAIL basic_vdb c=%0d got %b exp %b", c, {wr_valid_o, done_o, busy_o}, exp);
      end
      if (c == 1 || c == 6) begin
        checks++;
        if ({wr_mask_o, wr_data_o} !== ((c == 1) ? 64'hFFFF0000_A5A50000 : 64'h0000FFFF_00005A5A)) begin
          errors++;
          $display("FAIL basic_write c=%0d got %h %h", c, wr_mask_o, wr_data_o);
        end
      end
    end
  endtask

  task automatic test_stall();
    logic [2:0] exp;
    write_entry(0, 32'h0F0F0F0F, 32'h12345678, 2);
    wr_ready_i = 1'b0; start_i = 1'b1; len_i = 4'd1; loop_i = 1'b0;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk_i);
      start_i = 1'b0;
      exp = {c <= 6, c == 10, c < 10};
      checks++;
      if ({wr_valid_o, done_o, busy_o} !== exp) begin
        errors++;
        $display("FAIL stall_vdb c=%0d got %b exp %b", c, {wr_valid_o, done_o, busy_o}, exp);
      end
      if (c <= 6) begin
        checks++;
        if ({wr_mask_o, wr_data_o} !== 64'h0F0F0F0F_12345678) begin
          errors++;
          $display("FAIL stall_stable c=%0d got %h %h exp 0f0f0f0f 12345678", c, wr_mask_o, wr_data_o);
        end
      end
      wr_ready_i = (c >= 6);
    end
  endtask

  task automatic test_len0_stop();
    logic [2:0] exp;
    start_i = 1'b1; len_i = 4'd0;
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk_i);
      start_i = 1'b0;
      exp = {1'b0, c == 1, 1'b0};
      checks++;
      if ({wr_valid_o, done_o, busy_o} !== exp) begin
        errors++;
        $display("FAIL len0 c=%0d got %b exp %b", c, {wr_valid_o, done_o, busy_o}, exp);
      end
    end
    start_i = 1'b1; stop_i = 1'b1; len_i = 4'd2;
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk_i);
      start_i = 1'b0;
      stop_i  = 1'b0;
      checks++;
      if ({wr_valid_o, done_o, busy_o} !== 3'b000) begin
        errors++;
        $display("FAIL start_stop c=%0d got %b exp 000", c, {wr_valid_o, done_o, busy_o});
      end
    end
  endtask

  task automatic test_loop();
    write_entry(0, $urandom, $urandom, 1);
    write_entry(1, $urandom, $urandom, 0);
    write_entry(2, $urandom, $urandom, 2);
    run_model(3, 1'b1, 1'b0, 4);
    run_model(3, 1'b1, 1'b1, 2);
  endtask

  task automatic test_busy_write();
    write_entry(0, 32'h11112222, 32'h33334444, 1);
    write_entry(1, 32'h55556666, 32'h77778888, 2);
    wr_ready_i = 1'b1; start_i = 1'b1; len_i = 4'd2; loop_i = 1'b1;
    repeat (3) begin
      @(negedge clk_i);
      start_i = 1'b0;
    end
    cfg_we_i = 1'b1; cfg_addr_i = 3'd1; cfg_mask_i = 32'hDEADBEEF; cfg_data_i = 32'hCAFEF00D; cfg_hold_i = 16'd7;
    @(negedge clk_i);
    cfg_we_i = 1'b0;
    stop_i   = 1'b1;
    @(negedge clk_i);
    stop_i = 1'b0;
    checks++;
    if (busy_o !== 1'b0) begin
      errors++;
      $display("FAIL busy_write_stop got busy=%b exp 0", busy_o);
    end
    run_model(2, 1'b0, 1'b1, 0);
  endtask

  task automatic test_random();
    for (int t = 0; t < 6; t++) begin
      for (int a = 0; a < Depth; a++) write_entry(a, $urandom, $urandom, $urandom_range(0, 4));
      run_model($urandom_range(1, 15), 1'b0, 1'b1, 0);
    end
  endtask

  task automatic test_reset_mid();
    write_entry(0, 32'h89ABCDEF, 32'h01234567, 20);
    wr_ready_i = 1'b1; start_i = 1'b1; len_i = 4'd1; loop_i = 1'b0;
    repeat (4) begin
      @(negedge clk_i);
      start_i = 1'b0;
    end
    #1 rst_ni = 1'b0;
    #1;
    checks++;
    if ({wr_valid_o, wr_mask_o, wr_data_o, busy_o, done_o, idx_o, pass_cnt_o} !== '0) begin
      errors++;
      $display("FAIL reset_mid_hold got v=%b m=%h d=%h b=%b dn=%b i=%0d p=%0d exp all zero",
               wr_valid_o, wr_mask_o, wr_data_o, busy_o, done_o, idx_o, pass_cnt_o);
    end
    @(negedge clk_i);
    rst_ni = 1'b1;
    clear_model();
    write_entry(1, 32'h0000_00FF, 32'h0000_0055, 0);
    wr_ready_i = 1'b0; start_i = 1'b1; len_i = 4'd2;
    @(negedge clk_i);
    start_i = 1'b0;
    checks++;
    if (wr_valid_o !== 1'b1) begin
      errors++;
      $display("FAIL reset_issue_pre got valid=%b exp 1", wr_valid_o);
    end
    #1 rst_ni = 1'b0;
    #1;
    checks++;
    if ({wr_valid_o, busy_o} !== 2'b00) begin
      errors++;
      $display("FAIL reset_async_drop got valid=%b busy=%b exp 0 0", wr_valid_o, busy_o);
    end
    @(negedge clk_i);
    rst_ni = 1'b1;
    clear_model();
    run_model(1, 1'b0, 1'b0, 0);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_len0_stop();
    test_loop();
    test_busy_write();
    test_random();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
